// File: rtl/nand_cmd_addr_seq.sv
// NAND command/address phase sequencer: CMD1, 0-5 address bytes, optional
// CMD2, optional tWB + R/B# wait, then a one-cycle done pulse.
module nand_cmd_addr_seq #(
    parameter int TWP = 2,
    parameter int TWH = 2,
    parameter int TWB = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  cmd1,
    input  logic [7:0]  cmd2,
    input  logic        has_cmd2,
    input  logic [1:0]  addr_mode,
    input  logic        wait_rb,
    input  logic [15:0] addr_column,
    input  logic [23:0] addr_row,
    input  logic        rb_n,
    output logic        busy,
    output logic        done,
    output logic        cle,
    output logic        ale,
    output logic        we_n,
    output logic [7:0]  dq_out,
    output logic        dq_oe
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD1,
        S_ADDR,
        S_CMD2,
        S_TWB,
        S_RB,
        S_DONE
    } state_t;

    localparam int BUS  = TWP + TWH;
    localparam int CMAX = (BUS > TWB) ? BUS : TWB;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0] BUS_LAST = CW'(BUS - 1);
    localparam logic [CW-1:0] TWB_LAST = CW'(TWB - 1);
    localparam logic [CW-1:0] TWP_CNT  = CW'(TWP);

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [2:0]    bcnt, bcnt_d;

    logic [7:0]  cmd1_q, cmd2_q;
    logic        has_cmd2_q, wait_rb_q;
    logic [1:0]  mode_q;
    logic [15:0] col_q;
    logic [23:0] row_q;

    logic        accept;
    logic        bus_d;
    logic [2:0]  addr_last;
    logic [2:0]  addr_pos;
    logic [7:0]  addr_byte;
    logic [7:0]  dq_d;
    state_t      after_addr, after_cmd1;

    assign accept = start && (state == S_IDLE);

    // Operand latch: captured once per accepted request, held until next one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd1_q     <= 8'h00;
            cmd2_q     <= 8'h00;
            has_cmd2_q <= 1'b0;
            wait_rb_q  <= 1'b0;
            mode_q     <= 2'b00;
            col_q      <= 16'h0000;
            row_q      <= 24'h000000;
        end else if (accept) begin
            cmd1_q     <= cmd1;
            cmd2_q     <= cmd2;
            has_cmd2_q <= has_cmd2;
            wait_rb_q  <= wait_rb;
            mode_q     <= addr_mode;
            col_q      <= addr_column;
            row_q      <= addr_row;
        end
    end

    // Address byte lookup and successor states for the optional phases.
    always_comb begin
        addr_last = 3'd0;
        case (mode_q)
            2'b01:   addr_last = 3'd4;
            2'b10:   addr_last = 3'd2;
            2'b11:   addr_last = 3'd1;
            default: addr_last = 3'd0;
        endcase
        addr_pos = (mode_q == 2'b10) ? (bcnt_d + 3'd2) : bcnt_d;
        addr_byte = 8'h00;
        case (addr_pos)
            3'd0:    addr_byte = col_q[7:0];
            3'd1:    addr_byte = col_q[15:8];
            3'd2:    addr_byte = row_q[7:0];
            3'd3:    addr_byte = row_q[15:8];
            3'd4:    addr_byte = row_q[23:16];
            default: addr_byte = 8'h00;
        endcase
        if (has_cmd2_q)
            after_addr = S_CMD2;
        else if (wait_rb_q)
            after_addr = S_TWB;
        else
            after_addr = S_DONE;
        after_cmd1 = (mode_q != 2'b00) ? S_ADDR : after_addr;
    end

    // Next-state logic: phase counter paces bus cycles and the tWB delay.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        bcnt_d  = bcnt;
        case (state)
            S_IDLE: begin
                cnt_d  = '0;
                bcnt_d = 3'd0;
                if (start)
                    state_d = S_CMD1;
            end
            S_CMD1: begin
                if (cnt == BUS_LAST) begin
                    cnt_d   = '0;
                    state_d = after_cmd1;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            S_ADDR: begin
                if (cnt == BUS_LAST) begin
                    cnt_d = '0;
                    if (bcnt == addr_last)
                        state_d = after_addr;
                    else
                        bcnt_d = bcnt + 3'd1;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            S_CMD2: begin
                if (cnt == BUS_LAST) begin
                    cnt_d   = '0;
                    state_d = wait_rb_q ? S_TWB : S_DONE;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            S_TWB: begin
                if (cnt == TWB_LAST) begin
                    cnt_d   = '0;
                    state_d = S_RB;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            S_RB: begin
                if (rb_n)
                    state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                bcnt_d  = 3'd0;
            end
        endcase
    end

    // Output byte for the bus cycle being entered; CMD1 uses the live input
    // on the accept edge because the latch loads on that same edge.
    always_comb begin
        bus_d = (state_d == S_CMD1) || (state_d == S_ADDR) ||
                (state_d == S_CMD2);
        dq_d  = 8'h00;
        case (state_d)
            S_CMD1:  dq_d = (state == S_IDLE) ? cmd1 : cmd1_q;
            S_ADDR:  dq_d = addr_byte;
            S_CMD2:  dq_d = cmd2_q;
            default: dq_d = 8'h00;
        endcase
    end

    // State register and registered pin outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            bcnt   <= 3'd0;
            busy   <= 1'b0;
            done   <= 1'b0;
            cle    <= 1'b0;
            ale    <= 1'b0;
            we_n   <= 1'b1;
            dq_out <= 8'h00;
            dq_oe  <= 1'b0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            bcnt   <= bcnt_d;
            busy   <= (state_d != S_IDLE);
            done   <= (state_d == S_DONE);
            cle    <= (state_d == S_CMD1) || (state_d == S_CMD2);
            ale    <= (state_d == S_ADDR);
            we_n   <= !(bus_d && (cnt_d < TWP_CNT));
            dq_out <= dq_d;
            dq_oe  <= bus_d;
        end
    end

endmodule

// File: tb/tb_nand_cmd_addr_seq.sv
// Bench for nand_cmd_addr_seq: directed sequences, expected bus bytes and
// done cycles queued by stimulus and checked by a negedge monitor.
module tb_nand_cmd_addr_seq;

    localparam int TWP = 2;
    localparam int TWH = 2;
    localparam int TWB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  cmd1 = 8'h00;
    logic [7:0]  cmd2 = 8'h00;
    logic        has_cmd2 = 1'b0;
    logic [1:0]  addr_mode = 2'b00;
    logic        wait_rb = 1'b0;
    logic [15:0] addr_column = 16'h0000;
    logic [23:0] addr_row = 24'h000000;
    logic        rb_n = 1'b1;
    logic        busy, done, cle, ale, we_n, dq_oe;
    logic [7:0]  dq_out;

    nand_cmd_addr_seq #(.TWP(TWP), .TWH(TWH), .TWB(TWB)) dut (
        .clk(clk), .rst(rst), .start(start), .cmd1(cmd1), .cmd2(cmd2),
        .has_cmd2(has_cmd2), .addr_mode(addr_mode), .wait_rb(wait_rb),
        .addr_column(addr_column), .addr_row(addr_row), .rb_n(rb_n),
        .busy(busy), .done(done), .cle(cle), .ale(ale), .we_n(we_n),
        .dq_out(dq_out), .dq_oe(dq_oe)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_seen = 0;
    logic [9:0] exp_q[$];
    int done_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    logic prev_we = 1'b1;
    int   low_cnt = 0;
    logic [9:0] e;
    int   dc;

    // Monitor: pops expected bytes at each WE# fall, done cycle at done.
    always @(negedge clk) begin
        if (rst) begin
            prev_we = 1'b1;
            low_cnt = 0;
        end else begin
            if (we_n == 1'b0) begin
                if (prev_we == 1'b1) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL bus_cycle: got unexpected byte %0h required none", dq_out);
                    end else begin
                        e = exp_q.pop_front();
                        chk("bus_byte", {22'd0, cle, ale, dq_out}, {22'd0, e});
                        chk("bus_oe", {31'd0, dq_oe}, 32'd1);
                    end
                    low_cnt = 0;
                end
                low_cnt++;
            end else if (prev_we == 1'b0) begin
                chk("we_low_width", low_cnt, TWP);
            end
            if (!busy)
                chk("idle_pins", {28'd0, cle, ale, dq_oe, we_n}, 32'd1);
            if (done) begin
                done_seen++;
                if (done_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL done: got unexpected done at %0d required none", cyc);
                end else begin
                    dc = done_q.pop_front();
                    chk("done_cycle", cyc, dc);
                    chk("bytes_left", exp_q.size(), 0);
                    chk("busy_at_done", {31'd0, busy}, 32'd1);
                end
            end
            prev_we = we_n;
        end
    end

    task automatic pb(input logic [1:0] ca, input logic [7:0] b);
        exp_q.push_back({ca, b});
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called #1 after a posedge; start is high for exactly that cycle.
    task automatic issue(input logic [7:0] c1, input logic [7:0] c2,
                         input logic h2, input logic [1:0] m,
                         input logic wrb, input logic [15:0] col,
                         input logic [23:0] row, output int s);
        cmd1 = c1;
        cmd2 = c2;
        has_cmd2 = h2;
        addr_mode = m;
        wait_rb = wrb;
        addr_column = col;
        addr_row = row;
        start = 1'b1;
        s = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        cmd1 = 8'hEE;
        cmd2 = 8'hEE;
        has_cmd2 = 1'b1;
        addr_mode = 2'b01;
        wait_rb = 1'b1;
        addr_column = 16'hFFFF;
        addr_row = 24'hFFFFFF;
        chk("busy_on_accept", {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_done(input int target, input int limit);
        int k;
        k = 0;
        while (done_seen < target && k < limit) begin
            @(posedge clk);
            #1;
            k++;
        end
        checks++;
        if (done_seen < target) begin
            errors++;
            $display("FAIL done_timeout: got %0d dones required %0d", done_seen, target);
        end
    endtask

    localparam logic [1:0] C = 2'b10;
    localparam logic [1:0] A = 2'b01;

    initial begin
        int s;
        int s2;
        #1000000;
        $display("FAIL global_timeout: got no finish required finish");
        $fatal(1, "timeout");
    end

    initial begin
        int s;
        int s2;
        repeat (2) @(negedge clk);
        chk("rst_pins", {20'd0, busy, done, cle, ale, we_n, dq_oe, dq_out[5:0]},
            {20'd0, 6'b000010, 6'd0});
        chk("rst_dq", {24'd0, dq_out}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // T1 read page
        pb(C, 8'h00); pb(A, 8'h04); pb(A, 8'h08); pb(A, 8'h45);
        pb(A, 8'h23); pb(A, 8'h01); pb(C, 8'h30);
        issue(8'h00, 8'h30, 1'b1, 2'b01, 1'b0, 16'h0804, 24'h012345, s);
        done_q.push_back(s + 29);
        wait_done(1, 60);

        // T2 block erase with R/B# busy for 20 clocks
        pb(C, 8'h60); pb(A, 8'hEF); pb(A, 8'hCD); pb(A, 8'hAB); pb(C, 8'hD0);
        issue(8'h60, 8'hD0, 1'b1, 2'b10, 1'b1, 16'h0000, 24'hABCDEF, s);
        goto(s + 19);
        rb_n = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rb_n = 1'b1;
        done_q.push_back(cyc + 1);
        wait_done(2, 20);

        // Reset command waiting on an already-ready R/B#: tWB then 1 cycle
        pb(C, 8'hFF);
        issue(8'hFF, 8'h00, 1'b0, 2'b00, 1'b1, 16'h0000, 24'h000000, s);
        done_q.push_back(s + 1 + 4 + TWB + 1);
        wait_done(3, 30);

        // T3 status, then T6 back-to-back start in the cycle after done
        pb(C, 8'h70);
        issue(8'h70, 8'h00, 1'b0, 2'b00, 1'b0, 16'h0000, 24'h000000, s);
        done_q.push_back(s + 5);
        goto(s + 6);
        chk("busy_after_done", {31'd0, busy}, 32'd0);
        chk("done_count_t3", done_seen, 4);
        pb(C, 8'h90); pb(A, 8'h00); pb(A, 8'h5A);
        issue(8'h90, 8'h00, 1'b0, 2'b11, 1'b0, 16'h5A00, 24'h000000, s2);
        chk("b2b_start_cycle", s2, s + 6);
        done_q.push_back(s2 + 13);
        wait_done(5, 30);

        // T4 start pulsed mid-ADDR is ignored
        pb(C, 8'h80); pb(A, 8'h34); pb(A, 8'h12); pb(C, 8'h10);
        issue(8'h80, 8'h10, 1'b1, 2'b11, 1'b0, 16'h1234, 24'h000000, s);
        done_q.push_back(s + 17);
        goto(s + 8);
        cmd1 = 8'hAA;
        cmd2 = 8'hBB;
        addr_mode = 2'b01;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(6, 30);

        // T5 reset during 3rd address byte
        pb(C, 8'h00); pb(A, 8'h04); pb(A, 8'h08); pb(A, 8'h45);
        issue(8'h00, 8'h30, 1'b1, 2'b01, 1'b0, 16'h0804, 24'h012345, s);
        goto(s + 14);
        chk("pre_rst_we", {31'd0, we_n}, 32'd0);
        rst = 1'b1;
        #1;
        chk("mid_rst_pins", {26'd0, busy, done, cle, ale, we_n, dq_oe},
            {26'd0, 6'b000010});
        chk("mid_rst_dq", {24'd0, dq_out}, 32'd0);
        chk("bytes_after_rst", exp_q.size(), 0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        pb(C, 8'h70);
        issue(8'h70, 8'h00, 1'b0, 2'b00, 1'b0, 16'h0000, 24'h000000, s);
        done_q.push_back(s + 5);
        wait_done(7, 30);
        repeat (3) @(posedge clk);
        chk("done_q_empty", done_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
